// File: rtl/an_code_pkg.sv
// ============================================================================
// Module      : an_code_pkg
// Description : AN-code constants and encoder state encoding (shared with SEC decoder)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package an_code_pkg;

  localparam int unsigned A      = 83;
  localparam int unsigned A_BITS = 7;
  localparam int unsigned N_BITS = 28;
  localparam int unsigned W_BITS = 36;
  localparam int unsigned P_BITS = 6;

  localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_INJ  = 2'd2,
    ST_HOLD = 2'd3
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/an_encoder_28bits_clk_if.sv
// ============================================================================
// Module      : an_encoder_28bits_clk_if
// Description : Input/output handshake bundle of the AN-code encoder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface an_encoder_28bits_clk_if;
  import an_code_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] N;
  logic              inj_en;
  logic              inj_neg;
  logic [P_BITS-1:0] inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [W_BITS-1:0] W;

  modport master (
    output in_valid, N, inj_en, inj_neg, inj_pos, out_ready,
    input  in_ready, out_valid, W
  );

  modport slave (
    input  in_valid, N, inj_en, inj_neg, inj_pos, out_ready,
    output in_ready, out_valid, W
  );

endinterface

`default_nettype wire

// File: rtl/an_shift_add_mul.sv
// ============================================================================
// Module      : an_shift_add_mul
// Description : LSB-first shift-add multiply of the data word by the constant A
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module an_shift_add_mul
  import an_code_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_start,
  input  wire logic [N_BITS-1:0] i_n,
  output logic      [W_BITS-1:0] o_acc,
  output logic                   o_done
);

  localparam int unsigned          CNT_BITS = $clog2(A_BITS);
  localparam logic [CNT_BITS-1:0]  c_LAST   = CNT_BITS'(A_BITS - 1);

  logic [CNT_BITS-1:0] r_cnt;
  logic                r_busy;
  logic [W_BITS-1:0]   r_acc;
  logic [W_BITS-1:0]   w_term;

  always_comb begin
    w_term = '0;
    if (A_VEC[r_cnt]) begin
      w_term = W_BITS'(i_n) << r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= r_acc + w_term;
      r_cnt <= r_cnt + CNT_BITS'(1);
      if (r_cnt == c_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Combinational so the caller can leave MUL on the same edge as the last add.
  assign o_done = r_busy && (r_cnt == c_LAST);
  assign o_acc  = r_acc;

endmodule

`default_nettype wire

// File: rtl/an_encoder_28bits_clk.sv
// ============================================================================
// Module      : an_encoder_28bits_clk
// Description : Sequential AN-code encoder W = A*N with optional +/-2^k error injection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module an_encoder_28bits_clk
  import an_code_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  an_encoder_28bits_clk_if.slave  bus
);

  enc_state_t        r_state;
  enc_state_t        w_next;
  logic [N_BITS-1:0] r_n;
  logic              r_inj_en;
  logic              r_inj_neg;
  logic [P_BITS-1:0] r_inj_pos;
  logic [W_BITS-1:0] r_w;

  logic              w_start;
  logic              w_done;
  logic [W_BITS-1:0] w_acc;
  logic              w_apply;
  logic [W_BITS-1:0] w_delta;
  logic [W_BITS-1:0] w_coded;

  an_shift_add_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_n     (r_n),
    .o_acc   (w_acc),
    .o_done  (w_done)
  );

  assign w_start = (r_state == ST_IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_next = ST_MUL;
      ST_MUL:  if (w_done)        w_next = ST_INJ;
      ST_INJ:                     w_next = ST_HOLD;
      ST_HOLD: if (bus.out_ready) w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Positions beyond the codeword are dropped rather than wrapped.
  assign w_apply = r_inj_en && (r_inj_pos < P_BITS'(W_BITS));
  assign w_delta = W_BITS'(1) << r_inj_pos;
  assign w_coded = !w_apply  ? w_acc :
                   r_inj_neg ? (w_acc - w_delta) : (w_acc + w_delta);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_inj_en  <= 1'b0;
      r_inj_neg <= 1'b0;
      r_inj_pos <= '0;
      r_w       <= '0;
    end else begin
      if (w_start) begin
        r_n       <= bus.N;
        r_inj_en  <= bus.inj_en;
        r_inj_neg <= bus.inj_neg;
        r_inj_pos <= bus.inj_pos;
      end
      if (r_state == ST_INJ) begin
        r_w <= w_coded;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.W         = r_w;

endmodule

`default_nettype wire

// File: tb/tb_an_encoder_28bits_clk.sv
// ============================================================================
// Module      : tb_an_encoder_28bits_clk
// Description : Self-checking bench: directed corner words plus random words vs arithmetic model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_an_encoder_28bits_clk;
  import an_code_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  an_encoder_28bits_clk_if bus ();

  an_encoder_28bits_clk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Codeword as plain modular arithmetic: (A*N +/- 2^pos) mod 2^W_BITS.
  function automatic logic [63:0] model(input longint unsigned n, input bit en,
                                        input bit neg, input int unsigned pos);
    longint unsigned v;
    v = longint'(A) * n;
    if (en && pos < W_BITS) begin
      if (neg) v = v - (64'd1 << pos);
      else     v = v + (64'd1 << pos);
    end
    return v & ((64'd1 << W_BITS) - 64'd1);
  endfunction

  task automatic encode(input logic [N_BITS-1:0] n, input bit en, input bit neg,
                        input logic [P_BITS-1:0] pos, input int hold);
    logic [63:0] exp;
    int          cyc;
    exp = model(64'(n), en, neg, int'(pos));
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("idle_ready", 64'(bus.in_ready), 64'd1);
    bus.N        = n;
    bus.inj_en   = en;
    bus.inj_neg  = neg;
    bus.inj_pos  = pos;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.N        = N_BITS'($urandom);
    check_eq("mul_ready_low", 64'(bus.in_ready), 64'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (!bus.out_valid && bus.in_ready) begin
        check_eq("busy_ready_low", 64'(bus.in_ready), 64'd0);
      end
    end
    check_eq("latency", 64'(cyc), 64'(A_BITS + 1));
    check_eq("codeword", 64'(bus.W), exp);
    check_eq("hold_ready_low", 64'(bus.in_ready), 64'd0);
    if (hold > 0) begin
      // New requests during HOLD must be ignored.
      bus.in_valid = 1'b1;
      bus.N        = N_BITS'($urandom);
      bus.inj_en   = 1'b1;
      bus.inj_pos  = P_BITS'($urandom);
      repeat (hold) @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_stable_W", 64'(bus.W), exp);
      check_eq("hold_ready_low2", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("accept_valid_low", 64'(bus.out_valid), 64'd0);
    check_eq("accept_ready_high", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.N         = '0;
    bus.inj_en    = 1'b0;
    bus.inj_neg   = 1'b0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_W", 64'(bus.W), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    encode(28'd0,         1'b0, 1'b0, 6'd0,  0);
    encode(28'd1,         1'b0, 1'b0, 6'd0,  0);
    encode(28'hFFFFFFF,   1'b0, 1'b0, 6'd0,  1);
    check_eq("max_product", 64'(bus.W), 64'd22280142765);
    encode(28'd5,         1'b1, 1'b0, 6'd3,  0);
    check_eq("plus_2p3", 64'(bus.W), 64'd423);
    encode(28'd5,         1'b1, 1'b1, 6'd0,  0);
    check_eq("minus_2p0", 64'(bus.W), 64'd414);
    encode(28'd0,         1'b1, 1'b1, 6'd0,  0);
    check_eq("underflow_wrap", 64'(bus.W), (64'd1 << 36) - 64'd1);
    encode(28'd12345,     1'b1, 1'b0, 6'd40, 0);
    encode(28'hFFFFFFF,   1'b1, 1'b0, 6'd35, 0);
    encode(28'd77,        1'b1, 1'b0, 6'd36, 0);
    encode(28'd1000,      1'b0, 1'b0, 6'd0,  20);

    // Async reset in the middle of a multiply aborts the word.
    bus.N        = 28'd999;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("midrst_no_output", 64'(bus.out_valid), 64'd0);
    encode(28'd4242, 1'b1, 1'b1, 6'd7, 0);

    for (int i = 0; i < 40; i++) begin
      encode(N_BITS'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             P_BITS'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
